// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: opcode encodings, default widths,
// FSM state encoding and an instruction-assembly helper.
package instruction_fetch_pkg;

    // Default geometry of the core's instruction path
    localparam int DEFAULT_ADDR_WIDTH  = 10;
    localparam int DEFAULT_INSTR_WIDTH = 16;
    localparam int OPCODE_WIDTH        = 6;
    localparam int FIELD_WIDTH         = DEFAULT_INSTR_WIDTH - OPCODE_WIDTH;
    localparam int PERF_CNT_WIDTH      = 16;

    // Opcode encodings shared across the core
    localparam logic [OPCODE_WIDTH-1:0] OP_NOP  = 6'h00;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDCA = 6'h01;
    localparam logic [OPCODE_WIDTH-1:0] OP_STCA = 6'h02;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 6'h03;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 6'h04;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = 6'h05;
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = 6'h06;

    // Fetch FSM: one boot cycle after reset, then normal running
    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

    // Assemble a default-width instruction word from opcode and field
    function automatic logic [DEFAULT_INSTR_WIDTH-1:0] make_instr(
        input logic [OPCODE_WIDTH-1:0] op,
        input logic [FIELD_WIDTH-1:0]  field
    );
        return {op, field};
    endfunction

endpackage

// File: rtl/instruction_fetch_perf_counters.sv
// fetch_perf_counters: three saturating event counters for the fetch stage
// (committed fetches, redirect bubbles, stalled cycles). Only built when
// FETCH_PERF_CNT_EN is defined.
module fetch_perf_counters
    import instruction_fetch_pkg::*;
(
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      iFetch,
    input  logic                      iBubble,
    input  logic                      iStall,
    output logic [PERF_CNT_WIDTH-1:0] oFetchCount,
    output logic [PERF_CNT_WIDTH-1:0] oBubbleCount,
    output logic [PERF_CNT_WIDTH-1:0] oStallCount
);

    // Each counter advances on its event and sticks at all-ones
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oFetchCount  <= '0;
            oBubbleCount <= '0;
            oStallCount  <= '0;
        end else begin
            if (iFetch && (oFetchCount != '1))
                oFetchCount <= oFetchCount + PERF_CNT_WIDTH'(1);
            if (iBubble && (oBubbleCount != '1))
                oBubbleCount <= oBubbleCount + PERF_CNT_WIDTH'(1);
            if (iStall && (oStallCount != '1))
                oStallCount <= oStallCount + PERF_CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the PC, addresses the combinational instruction
// ROM and registers the returned word into the IF/ID register. Redirects
// insert one NOP bubble; stalls freeze PC and IF/ID.
// Optional feature: define FETCH_PERF_CNT_EN to add saturating counters.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int                    INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   Clock,
    input  logic                   Reset,
    output logic [ADDR_WIDTH-1:0]  oRomAddress,
    input  logic [INSTR_WIDTH-1:0] iRomInstruction,
    input  logic                   iStall,
    input  logic                   iRedirect,
    input  logic [ADDR_WIDTH-1:0]  iRedirectPC,
    output logic [INSTR_WIDTH-1:0] oInstruction,
    output logic [ADDR_WIDTH-1:0]  oInstructionPC,
    output logic                   oValid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0] oFetchCount,
    output logic [PERF_CNT_WIDTH-1:0] oBubbleCount,
    output logic [PERF_CNT_WIDTH-1:0] oStallCount
`endif
);

    localparam logic [INSTR_WIDTH-1:0] NOP_WORD =
        {OP_NOP, {(INSTR_WIDTH-OPCODE_WIDTH){1'b0}}};

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  load_pc;   // take iRedirectPC (BOOT or RUN)
    logic                  bubble;    // RUN redirect: squash IF/ID
    logic                  commit;    // RUN fetch: capture ROM word

    assign oRomAddress = pc_q;

    // FSM state register
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state_q <= ST_BOOT;
        else        state_q <= state_d;
    end

    // Next state and per-cycle action, redirect > stall > fetch
    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        load_pc = 1'b0;
        bubble  = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                load_pc = iRedirect;
            end
            ST_RUN: begin
                if (iRedirect) begin
                    load_pc = 1'b1;
                    bubble  = 1'b1;
                end else if (!iStall) begin
                    commit  = 1'b1;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // PC and IF/ID register; PC wraps naturally modulo 2^ADDR_WIDTH
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pc_q           <= RESET_PC;
            oInstruction   <= NOP_WORD;
            oInstructionPC <= '0;
            oValid         <= 1'b0;
        end else begin
            if (load_pc)
                pc_q <= iRedirectPC;
            else if (commit)
                pc_q <= pc_q + ADDR_WIDTH'(1);

            if (bubble) begin
                oInstruction <= NOP_WORD;
                oValid       <= 1'b0;
            end else if (commit) begin
                oInstruction   <= iRomInstruction;
                oInstructionPC <= pc_q;
                oValid         <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic stall_cycle;
    assign stall_cycle = (state_q == ST_RUN) && !iRedirect && iStall;

    fetch_perf_counters u_perf (
        .Clock        (Clock),
        .Reset        (Reset),
        .iFetch       (commit),
        .iBubble      (bubble),
        .iStall       (stall_cycle),
        .oFetchCount  (oFetchCount),
        .oBubbleCount (oBubbleCount),
        .oStallCount  (oStallCount)
    );
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed table of the key
// scenarios, a perf-counter sequence with async reset, and a randomized run
// against a cycle-level behavioural model of the fetch rules.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    localparam int AW = 10;
    localparam int IW = 16;
    localparam int ROM_DEPTH = 1 << AW;
    localparam logic [IW-1:0] NOP = {OP_NOP, 10'd0};

    logic          Clock;
    logic          Reset;
    logic [AW-1:0] oRomAddress;
    logic [IW-1:0] iRomInstruction;
    logic          iStall;
    logic          iRedirect;
    logic [AW-1:0] iRedirectPC;
    logic [IW-1:0] oInstruction;
    logic [AW-1:0] oInstructionPC;
    logic          oValid;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0]   oFetchCount, oBubbleCount, oStallCount;
`endif

    logic [IW-1:0] rom [ROM_DEPTH];
    assign iRomInstruction = rom[oRomAddress];

    instruction_fetch #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC('0)) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .oRomAddress     (oRomAddress),
        .iRomInstruction (iRomInstruction),
        .iStall          (iStall),
        .iRedirect       (iRedirect),
        .iRedirectPC     (iRedirectPC),
        .oInstruction    (oInstruction),
        .oInstructionPC  (oInstructionPC),
        .oValid          (oValid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .oFetchCount     (oFetchCount),
        .oBubbleCount    (oBubbleCount),
        .oStallCount     (oStallCount)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the fetch rules applied to plain integers
    int            m_pc, m_ipc, m_fetch, m_bubble, m_stall;
    logic [IW-1:0] m_instr;
    bit            m_valid, m_boot;

    task automatic model_reset();
        m_pc = 0; m_ipc = 0; m_instr = NOP; m_valid = 0; m_boot = 1;
        m_fetch = 0; m_bubble = 0; m_stall = 0;
    endtask

    task automatic model_step(input bit stall, input bit redir, input int rpc);
        if (m_boot) begin
            if (redir) m_pc = rpc;
            m_boot = 0;
        end else if (redir) begin
            m_pc = rpc; m_instr = NOP; m_valid = 0; m_bubble++;
        end else if (stall) begin
            m_stall++;
        end else begin
            m_instr = rom[m_pc]; m_ipc = m_pc; m_valid = 1;
            m_pc = (m_pc + 1) % ROM_DEPTH; m_fetch++;
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".addr"},  32'(oRomAddress),    32'(m_pc));
        check({tag, ".valid"}, 32'(oValid),         32'(m_valid));
        check({tag, ".ipc"},   32'(oInstructionPC), 32'(m_ipc));
        check({tag, ".instr"}, 32'(oInstruction),   32'(m_instr));
`ifdef FETCH_PERF_CNT_EN
        check({tag, ".fcnt"}, 32'(oFetchCount),  32'(m_fetch));
        check({tag, ".bcnt"}, 32'(oBubbleCount), 32'(m_bubble));
        check({tag, ".scnt"}, 32'(oStallCount),  32'(m_stall));
`endif
    endtask

    // Called at a negedge: drive, clock once, compare, return at next negedge
    task automatic step(input string tag, input bit stall, input bit redir, input int rpc);
        iStall = stall; iRedirect = redir; iRedirectPC = AW'(rpc);
        model_step(stall, redir, rpc);
        @(posedge Clock);
        #1;
        compare_model(tag);
        @(negedge Clock);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".addr"},  32'(oRomAddress),    32'd0);
        check({tag, ".valid"}, 32'(oValid),         32'd0);
        check({tag, ".ipc"},   32'(oInstructionPC), 32'd0);
        check({tag, ".instr"}, 32'(oInstruction),   32'(NOP));
`ifdef FETCH_PERF_CNT_EN
        check({tag, ".fcnt"}, 32'(oFetchCount),  32'd0);
        check({tag, ".bcnt"}, 32'(oBubbleCount), 32'd0);
        check({tag, ".scnt"}, 32'(oStallCount),  32'd0);
`endif
    endtask

    // Mid-run async reset taken between edges; release at the next negedge
    task automatic async_reset(input string tag);
        #2 Reset = 1'b0;
        #1 check_reset_state(tag);
        model_reset();
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    typedef struct {
        bit      stall;
        bit      redir;
        int      rpc;
        int      exp_addr;
        bit      exp_valid;
        int      exp_ipc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(bit s, bit r, int rpc, int a, bit val, int ipc);
        vec_t t;
        t.stall = s; t.redir = r; t.rpc = rpc;
        t.exp_addr = a; t.exp_valid = val; t.exp_ipc = ipc;
        return t;
    endfunction

    initial begin
        // Directed scenarios, hand-derived from the fetch rules
        vecs.push_back(v(0, 0, 0,    0, 0, 0));     // BOOT edge: nothing committed
        vecs.push_back(v(0, 0, 0,    1, 1, 0));     // first valid on 2nd edge
        for (int i = 2; i <= 8; i++)
            vecs.push_back(v(0, 0, 0, i, 1, i - 1)); // free run, LDCA at 5
        for (int i = 0; i < 3; i++)
            vecs.push_back(v(1, 0, 0, 8, 1, 7));    // stall with PC=8
        vecs.push_back(v(0, 0, 0,    9, 1, 8));     // word at 8 committed
        vecs.push_back(v(0, 0, 0,   10, 1, 9));
        vecs.push_back(v(0, 0, 0,   11, 1, 10));
        vecs.push_back(v(0, 1, 7,    7, 0, 10));    // redirect at PC=11
        vecs.push_back(v(0, 0, 0,    8, 1, 7));
        vecs.push_back(v(1, 1, 26,  26, 0, 7));     // redirect beats stall
        vecs.push_back(v(0, 0, 0,   27, 1, 26));
        vecs.push_back(v(0, 1, 1023, 1023, 0, 26)); // redirect to top of space
        vecs.push_back(v(0, 0, 0,    0, 1, 1023));  // wrap
        vecs.push_back(v(0, 0, 0,    1, 1, 0));

        for (int i = 0; i < ROM_DEPTH; i++)
            rom[i] = make_instr(OP_ADD, 10'(i));
        rom[5] = make_instr(OP_LDCA, 10'd77);

        iStall = 0; iRedirect = 0; iRedirectPC = '0;
        Reset = 1'b0;
        model_reset();
        @(negedge Clock);
        @(negedge Clock);
        check_reset_state("reset");
        Reset = 1'b1;

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].stall, vecs[i].redir, vecs[i].rpc);
            check($sformatf("vec%0d.tbl_addr", i),  32'(oRomAddress),    32'(vecs[i].exp_addr));
            check($sformatf("vec%0d.tbl_valid", i), 32'(oValid),         32'(vecs[i].exp_valid));
            check($sformatf("vec%0d.tbl_ipc", i),   32'(oInstructionPC), 32'(vecs[i].exp_ipc));
            check($sformatf("vec%0d.tbl_instr", i), 32'(oInstruction),
                  vecs[i].exp_valid ? 32'(rom[vecs[i].exp_ipc]) : 32'(NOP));
            check($sformatf("vec%0d.no_x", i), 32'($isunknown({oRomAddress, oInstruction,
                  oInstructionPC, oValid})), 32'd0);
        end
        check("ldca_word", 32'(rom[5]), 32'(make_instr(OP_LDCA, 10'd77)));
`ifdef FETCH_PERF_CNT_EN
        check("tbl.fcnt", 32'(oFetchCount),  32'd15);
        check("tbl.bcnt", 32'(oBubbleCount), 32'd3);
        check("tbl.scnt", 32'(oStallCount),  32'd3);
`endif

        // Counter sequence: 10 fetches, 2 redirects, 3 stall cycles
        async_reset("mid_reset1");
        step("cnt.boot", 0, 0, 0);
        for (int i = 0; i < 5; i++) step("cnt.f", 0, 0, 0);
        step("cnt.r1", 0, 1, 100);
        for (int i = 0; i < 3; i++) step("cnt.s", 1, 0, 0);
        for (int i = 0; i < 3; i++) step("cnt.f", 0, 0, 0);
        step("cnt.r2", 1, 1, 200);
        for (int i = 0; i < 2; i++) step("cnt.f", 0, 0, 0);
`ifdef FETCH_PERF_CNT_EN
        check("cnt.fcnt", 32'(oFetchCount),  32'd10);
        check("cnt.bcnt", 32'(oBubbleCount), 32'd2);
        check("cnt.scnt", 32'(oStallCount),  32'd3);
`endif
        check("cnt.ipc", 32'(oInstructionPC), 32'd201);
        async_reset("mid_reset2");

        // Randomized run against the model over a random ROM image
        for (int i = 0; i < ROM_DEPTH; i++) rom[i] = IW'($urandom);
        for (int c = 0; c < 400; c++) begin
            bit s, r;
            int t;
            s = ($urandom_range(3) == 0);
            r = ($urandom_range(9) == 0);
            t = ($urandom_range(7) == 0) ? ROM_DEPTH - 1 - int'($urandom_range(2))
                                         : int'($urandom_range(ROM_DEPTH - 1));
            step($sformatf("rnd%0d", c), s, r, t);
            if (c == 200) async_reset("mid_reset3");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
